sparse_mac: RTL and testbench



---
 rtl/sparse_mac_if.sv | 21 ++
 rtl/sparse_mac.sv | 112 +++++++++++
 tb/tb_sparse_mac.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sparse_mac_if.sv
// sparse_mac_if: operand capture and result handshake bundle for sparse_mac
interface sparse_mac_if #(parameter int W = 20);
    logic signed [W-1:0] i_act [16];
    logic signed [W-1:0] i_wgt [16];
    logic [4:0]          i_n_pairs;
    logic                i_in_valid;
    logic                o_in_taken;
    logic signed [W-1:0] o_result;
    logic                o_out_valid;
    logic                i_out_taken;
    logic                o_sat;
    logic                o_busy;
    modport slave (
        input  i_act, i_wgt, i_n_pairs, i_in_valid, i_out_taken,
        output o_in_taken, o_result, o_out_valid, o_sat, o_busy
    );
    modport master (
        output i_act, i_wgt, i_n_pairs, i_in_valid, i_out_taken,
        input  o_in_taken, o_result, o_out_valid, o_sat, o_busy
    );
endinterface

// File: rtl/sparse_mac.sv
// sparse_mac: sequential dot product of up to 16 pairs, rescaled and saturated to Q(IL.FL); define MAC_ROUND_EN for round-half-up instead of floor
module sparse_mac #(
    parameter int IL        = 8,
    parameter int FL        = 12,
    parameter int ACC_GUARD = 4
) (
    input logic        clk,
    input logic        reset,
    sparse_mac_if.slave bus
);
    localparam int W    = IL + FL;
    localparam int ACCW = 2 * W + ACC_GUARD;
    localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MINV = {{(ACCW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, FINISH, DONE} state_t;

    state_t                 r_state, w_next;
    logic signed [W-1:0]    r_act [16];
    logic signed [W-1:0]    r_wgt [16];
    logic [4:0]             r_n;
    logic [3:0]             r_cnt;
    logic signed [ACCW-1:0] r_acc;
    logic                   r_in_taken;
    logic signed [W-1:0]    r_result;
    logic                   r_out_valid;
    logic                   r_sat;

    logic [4:0]             w_n_clamp;
    logic                   w_last;
    logic signed [2*W-1:0]  w_a, w_b, w_prod;
    logic signed [ACCW-1:0] w_rnd, w_scaled;
    logic                   w_hi, w_lo;

    assign w_n_clamp = bus.i_n_pairs > 5'd16 ? 5'd16 : bus.i_n_pairs;
    assign w_last    = {1'b0, r_cnt} == r_n - 5'd1;
    // operands are widened first so the product keeps its full Q(2IL.2FL) precision
    assign w_a       = {{W{r_act[r_cnt][W-1]}}, r_act[r_cnt]};
    assign w_b       = {{W{r_wgt[r_cnt][W-1]}}, r_wgt[r_cnt]};
    assign w_prod    = w_a * w_b;
`ifdef MAC_ROUND_EN
    assign w_rnd     = r_acc + (ACCW'(1) << (FL - 1));
`else
    assign w_rnd     = r_acc;
`endif
    assign w_scaled  = w_rnd >>> FL;
    assign w_hi      = w_scaled > MAXV;
    assign w_lo      = w_scaled < MINV;

    assign bus.o_in_taken  = r_in_taken;
    assign bus.o_result    = r_result;
    assign bus.o_out_valid = r_out_valid;
    assign bus.o_sat       = r_sat;
    assign bus.o_busy      = r_state != IDLE;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // next-state decode: capture in IDLE, n MAC cycles, one FINISH, hold in DONE until taken
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.i_in_valid) w_next = w_n_clamp != 5'd0 ? MAC : FINISH;
            MAC:     if (w_last) w_next = FINISH;
            FINISH:  w_next = DONE;
            DONE:    if (bus.i_out_taken) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // datapath: operand capture, accumulation, rescale/saturate and output handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 16; k++) begin
                r_act[k] <= '0;
                r_wgt[k] <= '0;
            end
            r_n         <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_in_taken  <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_in_taken <= r_state == IDLE && bus.i_in_valid;
            case (r_state)
                IDLE: if (bus.i_in_valid) begin
                    r_act <= bus.i_act;
                    r_wgt <= bus.i_wgt;
                    r_n   <= w_n_clamp;
                    r_cnt <= '0;
                    r_acc <= '0;
                end
                MAC: begin
                    r_acc <= r_acc + {{ACC_GUARD{w_prod[2*W-1]}}, w_prod};
                    r_cnt <= r_cnt + 4'd1;
                end
                FINISH: begin
                    r_result    <= w_hi ? {1'b0, {(W-1){1'b1}}} : w_lo ? {1'b1, {(W-1){1'b0}}} : w_scaled[W-1:0];
                    r_sat       <= w_hi || w_lo;
                    r_out_valid <= 1'b1;
                end
                DONE: if (bus.i_out_taken) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sparse_mac.sv
// tb_sparse_mac: directed and random jobs against a scoreboard of expected results
module tb_sparse_mac;
    localparam int W  = 20;
    localparam int FL = 12;

    typedef struct {
        logic signed [W-1:0] res;
        logic                sat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_job = 0;
    exp_t sb[$];
    logic signed [W-1:0] act [16];
    logic signed [W-1:0] wgt [16];
    logic signed [W-1:0] held;

    sparse_mac_if #(.W(W)) bus();
    sparse_mac dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int n);
        n_job = n;
        for (int k = 0; k < 16; k++) begin
            bus.i_act[k] = act[k];
            bus.i_wgt[k] = wgt[k];
        end
        bus.i_n_pairs  = 5'(n);
        bus.i_in_valid = 1'b1;
    endtask

    task automatic push_exp(input logic signed [W-1:0] r, input logic s);
        sb.push_back('{r, s});
    endtask

    function automatic exp_t model();
        longint s = 0;
        int     n = n_job > 16 ? 16 : n_job;
        exp_t   e;
        for (int k = 0; k < n; k++) s += longint'(act[k]) * longint'(wgt[k]);
`ifdef MAC_ROUND_EN
        s += longint'(1) << (FL - 1);
`endif
        s = s >>> FL;
        e.sat = (s > 524287) || (s < -524288);
        e.res = s > 524287 ? 20'sh7FFFF : s < -524288 ? 20'sh80000 : W'(s);
        return e;
    endfunction

    task automatic push_model();
        sb.push_back(model());
    endtask

    task automatic wait_taken(input string tag);
        int c = 0;
        do begin
            tick();
            c++;
        end while (!bus.o_in_taken && c < 5);
        check({tag, " in_taken"}, bus.o_in_taken, 1);
        bus.i_in_valid = 1'b0;
    endtask

    task automatic wait_result(input int lat, input string tag);
        int   c = 0;
        exp_t e;
        do begin
            tick();
            c++;
        end while (!bus.o_out_valid && c < 40);
        check({tag, " latency"}, c, lat);
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, " result"}, bus.o_result, e.res);
            check({tag, " sat"}, bus.o_sat, e.sat);
        end
    endtask

    task automatic take(input string tag);
        bus.i_out_taken = 1'b1;
        tick();
        bus.i_out_taken = 1'b0;
        check({tag, " out_valid cleared"}, bus.o_out_valid, 0);
    endtask

    task automatic job(input int n, input int lat, input string tag);
        apply(n);
        wait_taken(tag);
        wait_result(lat, tag);
        take(tag);
    endtask

    task automatic randomize_ops();
        for (int k = 0; k < 16; k++) begin
            act[k] = W'($urandom);
            wgt[k] = W'($urandom_range(0, 8191)) - 20'sd4096;
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            bus.i_act[k] = '0;
            bus.i_wgt[k] = '0;
        end
        bus.i_n_pairs   = '0;
        bus.i_in_valid  = 1'b0;
        bus.i_out_taken = 1'b0;
        #12;
        check("reset result", bus.o_result, 0);
        check("reset out_valid", bus.o_out_valid, 0);
        check("reset in_taken", bus.o_in_taken, 0);
        check("reset sat", bus.o_sat, 0);
        check("reset busy", bus.o_busy, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 16; k++) begin
            act[k] = W'(k * 37 + 5);
            wgt[k] = W'(k * 91 + 13);
        end
        act[0] = 20'sd4096;
        wgt[0] = 20'sd8192;
        act[1] = 20'sd2048;
        wgt[1] = -20'sd4096;
        push_exp(20'sd6144, 1'b0);
        job(2, 3, "basic");

        for (int k = 0; k < 16; k++) begin
            act[k] = 20'sd520192;
            wgt[k] = 20'sd520192;
        end
        push_exp(20'sd524287, 1'b1);
        job(16, 17, "sat_hi");
        for (int k = 0; k < 16; k++) wgt[k] = -20'sd520192;
        push_exp(-20'sd524288, 1'b1);
        job(16, 17, "sat_lo");

        push_exp(20'sd0, 1'b0);
        job(0, 1, "n0");
        for (int k = 0; k < 16; k++) begin
            act[k] = 20'sd4096;
            wgt[k] = 20'sd4096;
        end
        push_exp(20'sd65536, 1'b0);
        job(20, 17, "clamp");

        act[0] = 20'sd1;
        wgt[0] = 20'sd2048;
`ifdef MAC_ROUND_EN
        push_exp(20'sd1, 1'b0);
`else
        push_exp(20'sd0, 1'b0);
`endif
        job(1, 2, "round_pos");
        act[0] = -20'sd1;
`ifdef MAC_ROUND_EN
        push_exp(20'sd0, 1'b0);
`else
        push_exp(-20'sd1, 1'b0);
`endif
        job(1, 2, "round_neg");

        randomize_ops();
        apply(3);
        push_model();
        wait_taken("hold");
        wait_result(4, "hold");
        held = bus.o_result;
        randomize_ops();
        apply(2);
        push_model();
        for (int c = 0; c < 10; c++) begin
            tick();
            check("hold out_valid", bus.o_out_valid, 1);
            check("hold result", bus.o_result, held);
            check("hold no in_taken", bus.o_in_taken, 0);
        end
        bus.i_out_taken = 1'b1;
        tick();
        bus.i_out_taken = 1'b0;
        check("both out_valid cleared", bus.o_out_valid, 0);
        check("both no in_taken", bus.o_in_taken, 0);
        check("both idle", bus.o_busy, 0);
        tick();
        check("both capture next", bus.o_in_taken, 1);
        bus.i_in_valid = 1'b0;
        wait_result(3, "both");
        take("both");

        randomize_ops();
        apply(16);
        wait_taken("abort");
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("abort result", bus.o_result, 0);
        check("abort out_valid", bus.o_out_valid, 0);
        check("abort in_taken", bus.o_in_taken, 0);
        check("abort sat", bus.o_sat, 0);
        check("abort busy", bus.o_busy, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("abort stays idle", bus.o_busy, 0);
        randomize_ops();
        n_job = 5;
        push_model();
        job(5, 6, "after_abort");

        for (int j = 0; j < 4; j++) begin
            randomize_ops();
            n_job = int'($urandom_range(0, 16));
            push_model();
            job(n_job, n_job + 1, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
